stream_downscale: RTL and testbench
===================================

STREAM_DOWNSCALE -- requirements
Module: stream_downscale

Interface
REQ-001 Parameter T_DATA_WIDTH, default 8, SHALL set the bit width of one data lane.
REQ-002 Parameter S_KEEP_WIDTH, default 6, SHALL set the input lane count (wide side).
REQ-003 Parameter M_KEEP_WIDTH, default 2, SHALL set the output lane count; 1 <= M_KEEP_WIDTH < S_KEEP_WIDTH.
REQ-004 clk  in  1  SHALL be the clock; all state SHALL change on its rising edge.
REQ-005 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 s_data_in  in  T_DATA_WIDTH x S_KEEP_WIDTH (unpacked array)  SHALL carry the input lanes.
REQ-007 s_keep_in  in  S_KEEP_WIDTH  SHALL mark valid lanes; any pattern is allowed, including holes.
REQ-008 s_last_in, s_valid_in  in  1 each  SHALL be the packet end and beat valid.
REQ-009 s_ready_out  out  1  SHALL be the input ready.
REQ-010 m_data_out  out  T_DATA_WIDTH x M_KEEP_WIDTH  SHALL carry the output lanes.
REQ-011 m_keep_out  out  M_KEEP_WIDTH; m_last_out, m_valid_out  out  1 each; m_ready_in  in  1.

Function
REQ-012 A beat SHALL transfer on either side only when valid and ready are both 1 on a rising clk edge.
REQ-013 An accepted input beat with nonzero keep SHALL load a holding register: data, keep as the remaining-lane mask, and last.
- Consequence: first output beat valid the next cycle (latency 1).
REQ-014 Each output beat SHALL take the lowest-indexed up to M_KEEP_WIDTH remaining lanes, in ascending order, packed into output lanes 0.. upward.
- m_keep_out SHALL be contiguous ones from bit 0; unused output lanes SHALL drive data 0.
REQ-015 Lanes from different input beats SHALL never share one output beat.
REQ-016 m_last_out SHALL be 1 only on the final output beat of a held beat whose last=1.
REQ-017 On an output handshake, the emitted lanes SHALL be cleared from the remaining mask; the holding register SHALL empty when the mask reaches zero.
REQ-018 An accepted beat with keep=0 and last=1 SHALL produce exactly one output beat: m_keep_out=0, m_last_out=1.
REQ-019 An accepted beat with keep=0 and last=0 SHALL be discarded and produce no output.
REQ-020 s_ready_out SHALL equal (holding register empty) OR (m_valid_out AND m_ready_in AND current output beat is the final one of the held beat).
- This gives back-to-back operation with no bubble.
REQ-021 While m_valid_out=1 and m_ready_in=0, m_data_out, m_keep_out and m_last_out SHALL remain stable.
REQ-022 Input data SHALL be sampled only on an input handshake; s_data_in changes at other times SHALL have no effect.
REQ-023 Sustained throughput SHALL be one output beat per cycle while m_ready_in=1.

Reset
REQ-024 During reset: m_valid_out=0, m_last_out=0, m_keep_out=0, m_data_out all 0, holding register empty, s_ready_out=1.
REQ-025 Reset asserted mid-packet SHALL discard all held lanes; no partial beat SHALL be emitted after release.
REQ-026 The first cycle after release SHALL accept input normally.

Configuration
REQ-027 Macro STREAM_DOWNSCALE_PKT_CNT_EN, when defined, SHALL add output pkt_cnt_out (16 bits).
- Reset value 0; increments by 1 on each output handshake with m_last_out=1; wraps from 65535 to 0.
REQ-028 When STREAM_DOWNSCALE_PKT_CNT_EN is undefined, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Scenario: keep=6'b111111, data 1..6, last=1, m_ready=1 -> three output beats (1,2), (3,4), (5,6); keep 2'b11 each; last only on the third; s_ready low for 2 cycles.
REQ-030 Scenario: keep=6'b101001, data 10..15 -> beats (10,13) keep 2'b11, then (15,0) keep 2'b01.
REQ-031 Scenario: keep=0, last=1 -> one beat with keep 2'b00, last=1; then keep=0, last=0 -> no output, s_ready stays 1.
REQ-032 Scenario: m_ready held 0 for 5 cycles mid-packet -> outputs stable; no input accepted; no lanes lost or duplicated.
REQ-033 Scenario: rst_n pulsed low after the first output beat of a 6-lane beat -> m_valid=0 immediately; after release no stale lanes appear; next packet is correct.
REQ-034 Scenario (PKT_CNT_EN): 3 packets sent, then 65536 single-beat packets -> pkt_cnt_out reads 3, then 3 after wrap.

Source files
------------

// File: rtl/stream_downscale.sv
// Wide-to-narrow stream splitter: one held input beat is emitted as packed M-lane output beats, latency 1.
// Optional packet counter output enabled by STREAM_DOWNSCALE_PKT_CNT_EN; input stalls until the held beat drains.
module stream_downscale #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_KEEP_WIDTH = 6,
  parameter int M_KEEP_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_in [S_KEEP_WIDTH],
  input  logic [S_KEEP_WIDTH-1:0] s_keep_in,
  input  logic                    s_last_in,
  input  logic                    s_valid_in,
  output logic                    s_ready_out,
  output logic [T_DATA_WIDTH-1:0] m_data_out [M_KEEP_WIDTH],
  output logic [M_KEEP_WIDTH-1:0] m_keep_out,
  output logic                    m_last_out,
  output logic                    m_valid_out,
  input  logic                    m_ready_in
`ifdef STREAM_DOWNSCALE_PKT_CNT_EN
  ,
  output logic [15:0]             pkt_cnt_out
`endif
);

  logic [T_DATA_WIDTH-1:0] data_q [S_KEEP_WIDTH];
  logic [S_KEEP_WIDTH-1:0] keep_q;
  logic                    last_q;
  logic                    vld_q;

  logic [S_KEEP_WIDTH-1:0] emit_mask;
  logic                    final_beat;
  logic                    out_hs;
  logic                    in_hs;

  // keep_q is zero whenever the holder is empty, so outputs fall to zero without extra gating.
  always_comb begin
    int cnt;
    cnt       = 0;
    emit_mask = '0;
    m_keep_out = '0;
    for (int j = 0; j < M_KEEP_WIDTH; j++) begin
      m_data_out[j] = '0;
    end
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      if (keep_q[i]) begin
        for (int j = 0; j < M_KEEP_WIDTH; j++) begin
          if (cnt == j) begin
            m_data_out[j] = data_q[i];
            m_keep_out[j] = 1'b1;
            emit_mask[i]  = 1'b1;
          end
        end
        cnt = cnt + 1;
      end
    end
  end

  assign final_beat  = (keep_q & ~emit_mask) == '0;
  assign m_valid_out = vld_q;
  assign m_last_out  = vld_q & last_q & final_beat;
  assign out_hs      = vld_q & m_ready_in;
  assign s_ready_out = ~vld_q | (out_hs & final_beat);
  assign in_hs       = s_valid_in & s_ready_out;

  // A new beat may load in the same cycle the final output beat leaves, giving bubble-free flow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      keep_q <= '0;
      last_q <= 1'b0;
      data_q <= '{default: '0};
    end else begin
      if (out_hs) begin
        keep_q <= keep_q & ~emit_mask;
        if (final_beat) begin
          vld_q  <= 1'b0;
          last_q <= 1'b0;
        end
      end
      if (in_hs && (|s_keep_in || s_last_in)) begin
        vld_q  <= 1'b1;
        keep_q <= s_keep_in;
        last_q <= s_last_in;
        data_q <= s_data_in;
      end
    end
  end

`ifdef STREAM_DOWNSCALE_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
    end else if (out_hs && m_last_out) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt_out = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_stream_downscale.sv
// Directed bench for stream_downscale at default parameters (6 lanes in, 2 lanes out).
module tb_stream_downscale;

  logic       clk;
  logic       rst_n;
  logic [7:0] s_data_in [6];
  logic [5:0] s_keep_in;
  logic       s_last_in;
  logic       s_valid_in;
  logic       s_ready_out;
  logic [7:0] m_data_out [2];
  logic [1:0] m_keep_out;
  logic       m_last_out;
  logic       m_valid_out;
  logic       m_ready_in;
`ifdef STREAM_DOWNSCALE_PKT_CNT_EN
  logic [15:0] pkt_cnt_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  stream_downscale dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data_in   (s_data_in),
    .s_keep_in   (s_keep_in),
    .s_last_in   (s_last_in),
    .s_valid_in  (s_valid_in),
    .s_ready_out (s_ready_out),
    .m_data_out  (m_data_out),
    .m_keep_out  (m_keep_out),
    .m_last_out  (m_last_out),
    .m_valid_out (m_valid_out),
    .m_ready_in  (m_ready_in)
`ifdef STREAM_DOWNSCALE_PKT_CNT_EN
    ,
    .pkt_cnt_out (pkt_cnt_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic vld, input logic [7:0] d0,
                          input logic [7:0] d1, input logic [1:0] keep, input logic last,
                          input logic srdy);
    chk({tag, ".valid"}, {31'd0, m_valid_out}, {31'd0, vld});
    chk({tag, ".data"},  {16'd0, m_data_out[1], m_data_out[0]}, {16'd0, d1, d0});
    chk({tag, ".keep"},  {30'd0, m_keep_out}, {30'd0, keep});
    chk({tag, ".last"},  {31'd0, m_last_out}, {31'd0, last});
    chk({tag, ".s_rdy"}, {31'd0, s_ready_out}, {31'd0, srdy});
  endtask

  // Lane i carries base+i.
  task automatic drive(input logic vld, input logic [5:0] keep, input logic last,
                       input logic [7:0] base);
    s_valid_in = vld;
    s_keep_in  = keep;
    s_last_in  = last;
    for (int i = 0; i < 6; i++) s_data_in[i] = base + 8'(i);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    m_ready_in = 1'b1;
    drive(1'b0, 6'h00, 1'b0, 8'h00);
    #2;
    chk_beat("reset", 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b1);
    step();
    rst_n = 1'b1;
    step();

    // Full 6-lane beat splits into three pairs.
    drive(1'b1, 6'b111111, 1'b1, 8'd1);
    chk("full.s_rdy_idle", {31'd0, s_ready_out}, 32'd1);
    step();
    drive(1'b0, 6'b000000, 1'b0, 8'hEE);
    chk_beat("full.b0", 1'b1, 8'd1, 8'd2, 2'b11, 1'b0, 1'b0);
    step();
    chk_beat("full.b1", 1'b1, 8'd3, 8'd4, 2'b11, 1'b0, 1'b0);
    step();
    chk_beat("full.b2", 1'b1, 8'd5, 8'd6, 2'b11, 1'b1, 1'b1);
    step();
    chk_beat("full.done", 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b1);

    // Holes in keep: lanes 0,3,5.
    drive(1'b1, 6'b101001, 1'b1, 8'd10);
    step();
    drive(1'b0, 6'b000000, 1'b0, 8'h00);
    chk_beat("holes.b0", 1'b1, 8'd10, 8'd13, 2'b11, 1'b0, 1'b0);
    step();
    chk_beat("holes.b1", 1'b1, 8'd15, 8'd0, 2'b01, 1'b1, 1'b1);
    step();
    chk_beat("holes.done", 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b1);

    // Empty beats: last=1 yields one empty last beat, last=0 vanishes.
    drive(1'b1, 6'b000000, 1'b1, 8'd7);
    step();
    chk_beat("empty_last", 1'b1, 8'd0, 8'd0, 2'b00, 1'b1, 1'b1);
    drive(1'b1, 6'b000000, 1'b0, 8'd7);
    step();
    drive(1'b0, 6'b000000, 1'b0, 8'd0);
    chk_beat("empty_nolast", 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b1);
    step();
    chk_beat("empty_nolast2", 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b1);

    // Output stall mid-packet; a second beat waits and then follows with no bubble.
    drive(1'b1, 6'b111111, 1'b1, 8'd21);
    step();
    drive(1'b0, 6'b111111, 1'b0, 8'hE0);
    m_ready_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk_beat($sformatf("stall.c%0d", k), 1'b1, 8'd21, 8'd22, 2'b11, 1'b0, 1'b0);
      if (k == 2) drive(1'b1, 6'b000011, 1'b1, 8'd31);
      step();
    end
    chk_beat("stall.hold", 1'b1, 8'd21, 8'd22, 2'b11, 1'b0, 1'b0);
    m_ready_in = 1'b1;
    step();
    chk_beat("stall.b1", 1'b1, 8'd23, 8'd24, 2'b11, 1'b0, 1'b0);
    step();
    chk_beat("stall.b2", 1'b1, 8'd25, 8'd26, 2'b11, 1'b1, 1'b1);
    step();
    drive(1'b0, 6'b000000, 1'b0, 8'd0);
    chk_beat("stall.next", 1'b1, 8'd31, 8'd32, 2'b11, 1'b1, 1'b1);
    step();
    chk_beat("stall.done", 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b1);

    // Reset mid-packet discards held lanes.
    drive(1'b1, 6'b111111, 1'b1, 8'd41);
    step();
    drive(1'b0, 6'b000000, 1'b0, 8'd0);
    chk_beat("rst.b0", 1'b1, 8'd41, 8'd42, 2'b11, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    chk_beat("rst.during", 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b1);
    step();
    step();
    rst_n = 1'b1;
    drive(1'b1, 6'b000110, 1'b1, 8'd51);
    chk("rst.s_rdy_release", {31'd0, s_ready_out}, 32'd1);
    step();
    drive(1'b0, 6'b000000, 1'b0, 8'd0);
    chk_beat("rst.next", 1'b1, 8'd52, 8'd53, 2'b11, 1'b1, 1'b1);
    step();
    chk_beat("rst.done", 1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b1);

`ifdef STREAM_DOWNSCALE_PKT_CNT_EN
    rst_n = 1'b0;
    #1;
    chk("cnt.reset", {16'd0, pkt_cnt_out}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int p = 0; p < 3; p++) begin
      drive(1'b1, 6'b111000, 1'b1, 8'd60);
      step();
      drive(1'b0, 6'b000000, 1'b0, 8'd0);
      step();
      step();
    end
    chk("cnt.three", {16'd0, pkt_cnt_out}, 32'd3);
    drive(1'b1, 6'b000001, 1'b1, 8'd70);
    for (int p = 0; p < 65536; p++) step();
    drive(1'b0, 6'b000000, 1'b0, 8'd0);
    step();
    step();
    chk("cnt.wrap", {16'd0, pkt_cnt_out}, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
